// File: rtl/mpc_pkg.sv
// Shared definitions for the MPC compressor/decompressor pattern stages:
// pattern codes, line geometry and small line helpers.
package mpc_pkg;

  localparam int LINE_BITS             = 256;
  localparam int WORD_BITS             = 32;
  localparam int WORDS_PER_LINE        = LINE_BITS / WORD_BITS;
  localparam int LEN_BITS              = 9;
  localparam int MPC_NUM_PATTERNS      = 8;
  localparam int MPC_FIRST_TRANSFORMER = 2;
  localparam int MPC_LAST_TRANSFORMER  = 6;
  localparam int MPC_NUM_TRANSFORMER   = MPC_LAST_TRANSFORMER - MPC_FIRST_TRANSFORMER + 1;

  localparam int PAT_ZERO     = 0;
  localparam int PAT_WORDSAME = 1;
  localparam int PAT_UNCOMP   = MPC_NUM_PATTERNS - 1;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [LEN_BITS-1:0]  len_t;

  localparam len_t LINE_LEN = len_t'(LINE_BITS);
  localparam len_t WORD_LEN = len_t'(WORD_BITS);

  typedef enum logic [1:0] {
    ENC_ZERO     = 2'd0,
    ENC_WORDSAME = 2'd1,
    ENC_CAND     = 2'd2,
    ENC_UNCOMP   = 2'd3
  } enc_kind_e;

  function automatic len_t sat_len(input len_t len);
    return (len > LINE_LEN) ? LINE_LEN : len;
  endfunction

  function automatic logic is_word_same(input line_t line);
    logic same;
    same = 1'b1;
    for (int w = 0; w < WORDS_PER_LINE - 1; w++) begin
      same = same & (line[w*WORD_BITS +: WORD_BITS] == line[LINE_BITS-1 -: WORD_BITS]);
    end
    return same;
  endfunction

  // Keeps the top 'len' bits of a left-aligned payload; len of 256 keeps everything.
  function automatic line_t keep_msbs(input line_t data, input len_t len);
    line_t ones;
    ones = {LINE_BITS{1'b1}};
    return data & ~(ones >> len);
  endfunction

endpackage

// File: rtl/mpc_pattern_selector_if.sv
// Upstream (line + candidates) and downstream (encoded result) valid/ready
// bundle for the pattern selector.
interface mpc_pattern_selector_if #(
  parameter int NUM_TRANSFORMER = mpc_pkg::MPC_NUM_TRANSFORMER,
  parameter int LEN_ENCODE      = $clog2(mpc_pkg::MPC_NUM_PATTERNS)
);
  import mpc_pkg::*;

  logic                                  valid_i;
  logic                                  ready_o;
  logic [LINE_BITS-1:0]                  data_i;
  logic [LINE_BITS*NUM_TRANSFORMER-1:0]  cand_data_i;
  logic [LEN_BITS*NUM_TRANSFORMER-1:0]   cand_len_i;

  logic                                  valid_o;
  logic                                  ready_i;
  logic [LEN_ENCODE-1:0]                 select_o;
  logic [LEN_BITS-1:0]                   len_o;
  logic [LINE_BITS-1:0]                  data_o;

  modport master (
    output valid_i, data_i, cand_data_i, cand_len_i, ready_i,
    input  ready_o, valid_o, select_o, len_o, data_o
  );

  modport slave (
    input  valid_i, data_i, cand_data_i, cand_len_i, ready_i,
    output ready_o, valid_o, select_o, len_o, data_o
  );

endinterface

// File: rtl/mpc_min_len_tree.sv
// Combinational argmin over the candidate lengths; on equal lengths the
// lowest index (lowest pattern code) wins.
module mpc_min_len_tree
  import mpc_pkg::*;
#(
  parameter int NUM_IN   = MPC_NUM_TRANSFORMER,
  parameter int IDX_BITS = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0][LEN_BITS-1:0] lens,
  output logic [IDX_BITS-1:0]             min_idx,
  output len_t                            min_len
);

  logic [IDX_BITS-1:0] best_idx_s;
  len_t                best_len_s;

  // Strict less-than keeps the earlier index on ties.
  always_comb begin
    logic take;
    take       = 1'b0;
    best_idx_s = {IDX_BITS{1'b0}};
    best_len_s = lens[0];
    for (int i = 1; i < NUM_IN; i++) begin
      take       = (lens[i] < best_len_s);
      best_idx_s = take ? IDX_BITS'(i) : best_idx_s;
      best_len_s = take ? lens[i] : best_len_s;
    end
  end

  assign min_idx = best_idx_s;
  assign min_len = best_len_s;

endmodule

// File: rtl/mpc_pattern_selector.sv
// Two-stage selector: classifies a line and picks the shortest of zero,
// word-same, transformer candidates or uncompressed, with valid/ready on both sides.
module mpc_pattern_selector
  import mpc_pkg::*;
#(
  parameter int NUM_PATTERNS          = MPC_NUM_PATTERNS,
  parameter int NUM_FIRST_TRANSFORMER = MPC_FIRST_TRANSFORMER,
  parameter int NUM_LAST_TRANSFORMER  = MPC_LAST_TRANSFORMER,
  parameter int NUM_TRANSFORMER       = NUM_LAST_TRANSFORMER - NUM_FIRST_TRANSFORMER + 1,
  parameter int LEN_ENCODE            = $clog2(NUM_PATTERNS)
) (
  input logic                   clk,
  input logic                   rst_n,
  mpc_pattern_selector_if.slave bus
);

  localparam int IDX_BITS = (NUM_TRANSFORMER > 1) ? $clog2(NUM_TRANSFORMER) : 1;

  logic                                     en1_s;
  logic                                     en2_s;
  logic                                     v1_r;
  logic                                     v2_r;
  logic [NUM_TRANSFORMER-1:0][LEN_BITS-1:0] sat_len_s;
  logic [IDX_BITS-1:0]                      min_idx_s;
  len_t                                     min_len_s;
  enc_kind_e                                kind_s;

  line_t                                    line_r;
  logic [LINE_BITS*NUM_TRANSFORMER-1:0]     cand_data_r;
  enc_kind_e                                kind_r;
  logic [IDX_BITS-1:0]                      min_idx_r;
  len_t                                     min_len_r;
  line_t                                    cand_payload_s;

  logic [LEN_ENCODE-1:0]                    select_r;
  len_t                                     len_r;
  line_t                                    data_r;

  assign en2_s        = !v2_r || bus.ready_i;
  assign en1_s        = !v1_r || en2_s;
  assign bus.ready_o  = en1_s;
  assign bus.valid_o  = v2_r;
  assign bus.select_o = select_r;
  assign bus.len_o    = len_r;
  assign bus.data_o   = data_r;

  // Unpack candidate lengths (first code in the MSBs) and clamp them to a full line.
  always_comb begin
    for (int i = 0; i < NUM_TRANSFORMER; i++) begin
      sat_len_s[i] = sat_len(bus.cand_len_i[(NUM_TRANSFORMER-1-i)*LEN_BITS +: LEN_BITS]);
    end
  end

  mpc_min_len_tree #(
    .NUM_IN   (NUM_TRANSFORMER),
    .IDX_BITS (IDX_BITS)
  ) u_min_len_tree (
    .lens    (sat_len_s),
    .min_idx (min_idx_s),
    .min_len (min_len_s)
  );

  // Encoding priority: zero, then word-same, then a candidate shorter than a line.
  always_comb begin
    if (bus.data_i == {LINE_BITS{1'b0}}) begin
      kind_s = ENC_ZERO;
    end else if (is_word_same(bus.data_i)) begin
      kind_s = ENC_WORDSAME;
    end else if (min_len_s < LINE_LEN) begin
      kind_s = ENC_CAND;
    end else begin
      kind_s = ENC_UNCOMP;
    end
  end

  // Stage 1 registers: classification result plus the data stage 2 needs to build the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r        <= 1'b0;
      line_r      <= {LINE_BITS{1'b0}};
      cand_data_r <= {(LINE_BITS*NUM_TRANSFORMER){1'b0}};
      kind_r      <= ENC_ZERO;
      min_idx_r   <= {IDX_BITS{1'b0}};
      min_len_r   <= {LEN_BITS{1'b0}};
    end else if (en1_s) begin
      v1_r <= bus.valid_i;
      if (bus.valid_i) begin
        line_r      <= bus.data_i;
        cand_data_r <= bus.cand_data_i;
        kind_r      <= kind_s;
        min_idx_r   <= min_idx_s;
        min_len_r   <= min_len_s;
      end
    end
  end

  // Pick the winning candidate's payload slice.
  always_comb begin
    cand_payload_s = {LINE_BITS{1'b0}};
    for (int i = 0; i < NUM_TRANSFORMER; i++) begin
      cand_payload_s = (min_idx_r == IDX_BITS'(i))
                     ? cand_data_r[(NUM_TRANSFORMER-1-i)*LINE_BITS +: LINE_BITS]
                     : cand_payload_s;
    end
  end

  // Stage 2 output registers; they hold while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r     <= 1'b0;
      select_r <= {LEN_ENCODE{1'b0}};
      len_r    <= {LEN_BITS{1'b0}};
      data_r   <= {LINE_BITS{1'b0}};
    end else if (en2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        case (kind_r)
          ENC_ZERO: begin
            select_r <= LEN_ENCODE'(PAT_ZERO);
            len_r    <= {LEN_BITS{1'b0}};
            data_r   <= {LINE_BITS{1'b0}};
          end
          ENC_WORDSAME: begin
            select_r <= LEN_ENCODE'(PAT_WORDSAME);
            len_r    <= WORD_LEN;
            data_r   <= {line_r[LINE_BITS-1 -: WORD_BITS], {(LINE_BITS-WORD_BITS){1'b0}}};
          end
          ENC_CAND: begin
            select_r <= LEN_ENCODE'(NUM_FIRST_TRANSFORMER) + LEN_ENCODE'(min_idx_r);
            len_r    <= min_len_r;
            data_r   <= keep_msbs(cand_payload_s, min_len_r);
          end
          ENC_UNCOMP: begin
            select_r <= LEN_ENCODE'(NUM_PATTERNS - 1);
            len_r    <= LINE_LEN;
            data_r   <= line_r;
          end
          default: begin
            select_r <= LEN_ENCODE'(NUM_PATTERNS - 1);
            len_r    <= LINE_LEN;
            data_r   <= line_r;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpc_pattern_selector.sv
// Self-checking bench for mpc_pattern_selector: directed encodings, stall and
// ordering, random traffic against a reference model, and asynchronous reset.
module tb_mpc_pattern_selector;
  import mpc_pkg::*;

  localparam int NT = MPC_NUM_TRANSFORMER;

  typedef struct packed {
    logic [2:0]   sel;
    logic [8:0]   len;
    logic [255:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpc_pattern_selector_if bus ();

  mpc_pattern_selector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  int   inflight = 0;

  logic         s_ready, s_valid, s_rdy_i, s_in, s_out, s_exp_ready;
  logic [2:0]   s_sel;
  logic [8:0]   s_len;
  logic [255:0] s_data;

  // Reference: shortest encoding by the priority rules, plain arithmetic.
  function automatic res_t model(input logic [255:0] line, input logic [256*NT-1:0] cd,
                                 input logic [9*NT-1:0] cl);
    res_t r;
    logic [255:0] rep;
    int best, l, sh;
    r.sel = 3'(MPC_NUM_PATTERNS - 1);
    r.len = 9'd256;
    r.data = line;
    rep = {8{line[255:224]}};
    if (line == 256'd0) begin
      r.sel = 3'd0; r.len = 9'd0; r.data = 256'd0;
    end else if (line == rep) begin
      r.sel = 3'd1; r.len = 9'd32; r.data = {line[255:224], 224'd0};
    end else begin
      best = 256;
      for (int k = 0; k < NT; k++) begin
        l = int'(cl[(NT-1-k)*9 +: 9]);
        if (l > 256) l = 256;
        if (l < best) begin
          best = l;
          r.sel = 3'(MPC_FIRST_TRANSFORMER + k);
          r.len = 9'(l);
          sh = 256 - l;
          r.data = (cd[(NT-1-k)*256 +: 256] >> sh) << sh;
        end
      end
    end
    return r;
  endfunction

  task automatic gen_line(output logic [255:0] line, output logic [256*NT-1:0] cd,
                          output logic [9*NT-1:0] cl);
    int kind;
    logic [31:0] w;
    kind = $urandom_range(0, 5);
    for (int i = 0; i < 8*NT; i++) cd[i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
    for (int k = 0; k < NT; k++) cl[k*9 +: 9] = 9'($urandom_range(0, 511));
    case (kind)
      0: line = 256'd0;
      1: begin w = $urandom; line = {8{w}}; end
      3: for (int k = 0; k < NT; k++) cl[k*9 +: 9] = 9'(32 * $urandom_range(2, 4));
      4: for (int k = 0; k < NT; k++) cl[k*9 +: 9] = 9'($urandom_range(256, 511));
      default: ;
    endcase
  endtask

  // One clock: sample mid-cycle, record transfers, then advance past the edge.
  task automatic step();
    @(negedge clk);
    s_ready     = bus.ready_o;
    s_valid     = bus.valid_o;
    s_rdy_i     = bus.ready_i;
    s_sel       = bus.select_o;
    s_len       = bus.len_o;
    s_data      = bus.data_o;
    s_exp_ready = (inflight < 2) || bus.ready_i;
    s_in        = bus.valid_i && bus.ready_o;
    s_out       = bus.valid_o && bus.ready_i;
    if (s_in)  exp_q.push_back(model(bus.data_i, bus.cand_data_i, bus.cand_len_i));
    if (s_out) obs_q.push_back({s_sel, s_len, s_data});
    inflight = inflight + int'(s_in) - int'(s_out);
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [255:0] line, input logic [256*NT-1:0] cd,
                          input logic [9*NT-1:0] cl, output logic mid_valid);
    bus.ready_i = 1'b1;
    bus.data_i = line; bus.cand_data_i = cd; bus.cand_len_i = cl;
    bus.valid_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    step();
    mid_valid = s_valid;
    step();
  endtask

  task automatic drain(output bit ok);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 20 && inflight != 0; c++) step();
    ok = (inflight == 0);
  endtask

  task automatic test_reset();
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    bus.data_i = 256'd0; bus.cand_data_i = '0; bus.cand_len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
    checks++; if (bus.select_o !== 3'd0) begin failures++; $display("FAIL reset_select: got %0d expected 0", bus.select_o); end
    checks++; if (bus.len_o !== 9'd0) begin failures++; $display("FAIL reset_len: got %0d expected 0", bus.len_o); end
    checks++; if (bus.data_o !== 256'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", bus.data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
  endtask

  task automatic test_zero();
    logic [256*NT-1:0] cd; logic [9*NT-1:0] cl; logic [255:0] dummy; logic mid;
    gen_line(dummy, cd, cl);
    send_one(256'd0, cd, cl, mid);
    checks++; if (mid !== 1'b0) begin failures++; $display("FAIL zero_latency: valid_o after 1 cycle got %b expected 0", mid); end
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL zero_valid: got %b expected 1", s_valid); end
    checks++; if (s_sel !== 3'd0 || s_len !== 9'd0 || s_data !== 256'd0) begin
      failures++; $display("FAIL zero_result: got sel=%0d len=%0d data=%h expected 0/0/0", s_sel, s_len, s_data);
    end
  endtask

  task automatic test_wordsame();
    logic [256*NT-1:0] cd; logic [9*NT-1:0] cl; logic [255:0] dummy, line, expd; logic [31:0] w; logic mid;
    gen_line(dummy, cd, cl);
    w = 32'hDEADBEEF;
    line = {8{w}};
    expd = {w, 224'd0};
    send_one(line, cd, cl, mid);
    checks++; if (s_valid !== 1'b1 || s_sel !== 3'd1 || s_len !== 9'd32 || s_data !== expd) begin
      failures++; $display("FAIL wordsame: got v=%b sel=%0d len=%0d data=%h expected sel=1 len=32 data=%h", s_valid, s_sel, s_len, s_data, expd);
    end
  endtask

  task automatic test_candidate();
    logic [256*NT-1:0] cd; logic [9*NT-1:0] cl; logic [255:0] line, p, expd; logic mid;
    gen_line(line, cd, cl);
    line[31:0] = ~line[255:224];
    cl = {9'd200, 9'd96, 9'd96, 9'd300, 9'd255};
    p = cd[3*256 +: 256];
    expd = {p[255:160], 160'd0};
    send_one(line, cd, cl, mid);
    checks++; if (s_sel !== 3'd3 || s_len !== 9'd96 || s_data !== expd) begin
      failures++; $display("FAIL cand_tie: got sel=%0d len=%0d data=%h expected sel=3 len=96 data=%h", s_sel, s_len, s_data, expd);
    end
    cl = {9'd256, 9'd300, 9'd255, 9'd511, 9'd256};
    p = cd[2*256 +: 256];
    expd = {p[255:1], 1'b0};
    send_one(line, cd, cl, mid);
    checks++; if (s_sel !== 3'd4 || s_len !== 9'd255 || s_data !== expd) begin
      failures++; $display("FAIL cand_255: got sel=%0d len=%0d data=%h expected sel=4 len=255 data=%h", s_sel, s_len, s_data, expd);
    end
    cl = {9'd300, 9'd0, 9'd5, 9'd5, 9'd5};
    send_one(line, cd, cl, mid);
    checks++; if (s_sel !== 3'd3 || s_len !== 9'd0 || s_data !== 256'd0) begin
      failures++; $display("FAIL cand_len0: got sel=%0d len=%0d data=%h expected sel=3 len=0 data=0", s_sel, s_len, s_data);
    end
  endtask

  task automatic test_uncompressed();
    logic [256*NT-1:0] cd; logic [9*NT-1:0] cl; logic [255:0] line; logic mid;
    gen_line(line, cd, cl);
    line[31:0] = ~line[255:224];
    cl = {9'd256, 9'd400, 9'd511, 9'd256, 9'd300};
    send_one(line, cd, cl, mid);
    checks++; if (s_sel !== 3'd7 || s_len !== 9'd256 || s_data !== line) begin
      failures++; $display("FAIL uncomp: got sel=%0d len=%0d data=%h expected sel=7 len=256 data=%h", s_sel, s_len, s_data, line);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] lines[4]; logic [256*NT-1:0] cds[4]; logic [9*NT-1:0] cls[4];
    int idx; bit saw_low, ok; logic pv, pr; logic [2:0] psel; logic [8:0] plen; logic [255:0] pdata;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 4; i++) gen_line(lines[i], cds[i], cls[i]);
    idx = 0; saw_low = 0; pv = 0; pr = 1;
    psel = 3'd0; plen = 9'd0; pdata = 256'd0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      bus.ready_i = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
      bus.valid_i = 1'b1;
      bus.data_i = lines[idx]; bus.cand_data_i = cds[idx]; bus.cand_len_i = cls[idx];
      step();
      checks++; if (s_ready !== s_exp_ready) begin failures++; $display("FAIL b2b_ready: cycle %0d got %b expected %b", c, s_ready, s_exp_ready); end
      if (!s_ready) saw_low = 1;
      if (pv && !pr) begin
        checks++;
        if (s_valid !== 1'b1 || s_sel !== psel || s_len !== plen || s_data !== pdata) begin
          failures++; $display("FAIL b2b_stable: cycle %0d got v=%b sel=%0d len=%0d expected v=1 sel=%0d len=%0d", c, s_valid, s_sel, s_len, psel, plen);
        end
      end
      pv = s_valid; pr = s_rdy_i; psel = s_sel; plen = s_len; pdata = s_data;
      if (s_in) idx++;
    end
    checks++; if (idx != 4) begin failures++; $display("FAIL b2b_accept: accepted %0d lines expected 4", idx); end
    checks++; if (!saw_low) begin failures++; $display("FAIL b2b_backpressure: ready_o never low, expected low while full"); end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_drain: %0d lines still in flight expected 0", inflight); end
    checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL b2b_count: got %0d results expected 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL b2b_order[%0d]: got sel=%0d len=%0d data=%h expected sel=%0d len=%0d data=%h", i,
                             obs_q[i].sel, obs_q[i].len, obs_q[i].data, exp_q[i].sel, exp_q[i].len, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] line; logic [256*NT-1:0] cd; logic [9*NT-1:0] cl;
    bit ok; logic pv, pr; logic [2:0] psel; logic [8:0] plen; logic [255:0] pdata;
    exp_q.delete(); obs_q.delete();
    pv = 0; pr = 1; psel = 3'd0; plen = 9'd0; pdata = 256'd0;
    for (int c = 0; c < 200; c++) begin
      gen_line(line, cd, cl);
      bus.data_i = line; bus.cand_data_i = cd; bus.cand_len_i = cl;
      bus.valid_i = 1'($urandom_range(0, 1));
      bus.ready_i = ($urandom_range(0, 3) != 0);
      step();
      checks++; if (s_ready !== s_exp_ready) begin failures++; $display("FAIL rnd_ready: cycle %0d got %b expected %b", c, s_ready, s_exp_ready); end
      if (pv && !pr) begin
        checks++;
        if (s_valid !== 1'b1 || s_sel !== psel || s_len !== plen || s_data !== pdata) begin
          failures++; $display("FAIL rnd_stable: cycle %0d got v=%b sel=%0d len=%0d expected v=1 sel=%0d len=%0d", c, s_valid, s_sel, s_len, psel, plen);
        end
      end
      pv = s_valid; pr = s_rdy_i; psel = s_sel; plen = s_len; pdata = s_data;
    end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rnd_drain: %0d lines still in flight expected 0", inflight); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rnd_result[%0d]: got sel=%0d len=%0d data=%h expected sel=%0d len=%0d data=%h", i,
                             obs_q[i].sel, obs_q[i].len, obs_q[i].data, exp_q[i].sel, exp_q[i].len, exp_q[i].data);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [255:0] line; logic [256*NT-1:0] cd; logic [9*NT-1:0] cl; logic mid; res_t expr, got;
    bus.ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gen_line(line, cd, cl);
      bus.data_i = line; bus.cand_data_i = cd; bus.cand_len_i = cl;
      bus.valid_i = 1'b1;
      step();
    end
    bus.valid_i = 1'b0;
    step();
    checks++; if (s_valid !== 1'b1 || inflight != 2) begin failures++; $display("FAIL rst_preload: valid_o=%b inflight=%0d expected 1/2", s_valid, inflight); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b expected 0", bus.valid_o); end
    checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL rst_async_ready: got %b expected 1", bus.ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    inflight = 0; exp_q.delete(); obs_q.delete();
    bus.ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rst_no_ghost: cycle %0d valid_o got %b expected 0", c, s_valid); end
    end
    gen_line(line, cd, cl);
    expr = model(line, cd, cl);
    send_one(line, cd, cl, mid);
    got = {s_sel, s_len, s_data};
    checks++; if (s_valid !== 1'b1 || got !== expr) begin
      failures++; $display("FAIL rst_after: got v=%b sel=%0d len=%0d expected v=1 sel=%0d len=%0d", s_valid, got.sel, got.len, expr.sel, expr.len);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_wordsame();
    test_candidate();
    test_uncompressed();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpc_pattern_selector.md
Name: mpc_pattern_selector

Overview:
- Compressor-side counterpart of the decompressor's pattern select/detransform stage.
- Takes one 256-bit line and the candidate outputs of the transformer bank (payloads and bit lengths).
- Chooses the shortest encoding and emits the pattern code, length and payload to the packer.
- Two-stage pipeline with valid/ready flow control on both sides.

Parameters:
- NUM_PATTERNS, 8, total pattern codes (0 all-zero, 1 all-wordsame, NUM_PATTERNS-1 uncompressed).
- NUM_FIRST_TRANSFORMER, 2, code of first transformer.
- NUM_LAST_TRANSFORMER, 6, code of last transformer.
- NUM_TRANSFORMER, NUM_LAST_TRANSFORMER-NUM_FIRST_TRANSFORMER+1, number of candidates.
- LEN_ENCODE, $clog2(NUM_PATTERNS), width of pattern code.
- LEN_BITS, 9, width of length fields (0..256).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_i  input  1  input line and candidates valid.
- ready_o  output  1  selector can accept input this cycle.
- data_i  input  256  original uncompressed line.
- cand_data_i  input  256*NUM_TRANSFORMER  transformer payloads; code NUM_FIRST_TRANSFORMER in MSBs, codes increase toward LSBs, payload left-aligned.
- cand_len_i  input  LEN_BITS*NUM_TRANSFORMER  candidate lengths in bits, same packing order.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- select_o  output  LEN_ENCODE  chosen pattern code.
- len_o  output  LEN_BITS  payload length in bits.
- data_o  output  256  payload, left-aligned (MSB first), unused LSBs zero.

Behaviour:
- Reset: valid_o=0, select_o=0, len_o=0, data_o=0, all pipeline valids 0. ready_o=1 from the first cycle after reset deassertion.
- Handshake:
  - en2 = !v2 || ready_i.
  - en1 = !v1 || en2.
  - ready_o = en1.
  - A transfer occurs on valid_i && ready_o, or on valid_o && ready_i.
  - Full throughput of 1 line/cycle when ready_i is held high.
  - Latency is 2 cycles from input acceptance to valid_o.
- Stage 1 (on en1): captures valid_i into v1, plus data_i, cand_data_i, cand_len_i. Computes:
  - zero = (data_i==0).
  - same = all eight 32-bit words equal data_i[255:224].
  - Index and length of the minimum candidate. Ties resolve to the lowest code; the tree is permitted to split across the stage boundary.
- Stage 2 (on en2): registers v2 and the outputs.
- Priority, first match wins:
  - zero → select 0, len 0, data 0.
  - same → select 1, len 32, data {word, 224'b0}.
  - min candidate len < 256 → select = that code, len = its len, data = its payload with bits below len forced to 0.
  - otherwise → select NUM_PATTERNS-1, len 256, data = data_i.
- Candidate len > 256 is treated as 256 (saturate before compare).
- Output stability: select_o, len_o and data_o hold while valid_o && !ready_i.
- Data registers update only on enable; when v1=0 the data registers are don't-care, but valid_o must be 0.
- Reset mid-operation: all in-flight lines are dropped; no partial output after rst_n rises.
- Simultaneous accept and emit in the same cycle is legal and loses no line.

Decomposition:
- Shared package mpc_pkg:
  - Pattern code constants PAT_ZERO=0, PAT_WORDSAME=1, PAT_UNCOMP=NUM_PATTERNS-1.
  - LINE_BITS=256, WORD_BITS=32, LEN_BITS.
  - Shared with the decompressor.
- One sub-module: mpc_min_len_tree. Combinational argmin over NUM_TRANSFORMER lengths, lowest-index tie-break, outputs index and length.

Test Plan:
- data_i=0, ready_i=1 → 2 cycles later valid_o=1, select_o=0, len_o=0, data_o=0.
- data_i={8{32'hDEADBEEF}} → select_o=1, len_o=32, data_o={32'hDEADBEEF,224'b0}.
- Random nonzero data, cand_len={200,96,96,300,255} for codes 2..6 → select_o=3, len_o=96, data_o=code-3 payload with bits below 96 zeroed (tie with code 4 broken low).
- All cand_len ≥ 256 (e.g. {256,400,511,256,300}) → select_o=7, len_o=256, data_o=data_i.
- Stream 4 lines back-to-back, hold ready_i=0 for 3 cycles mid-stream → ready_o drops once both stages are full; outputs are stable while stalled; all 4 results arrive in order with no loss or duplication.
- Assert rst_n=0 with 2 lines in flight → valid_o=0 immediately (asynchronous); after release, valid_o stays 0 until a new input is accepted.
